window2d_reframer: RTL and testbench

Reconstructs a full-size raster frame from the interior-only result stream of a 2D window filter. Each result is the filtered value at one window centre, delivered in raster order. The block re-inserts the border pixels that the window cannot cover and emits a ready/valid raster with frame and line markers. It sits downstream of the window generator and its filter kernel, and feeds the video output path.

---
 rtl/window2d_reframer.sv | 233 +++++++++++++++++++++++
 tb/tb_window2d_reframer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window2d_reframer.sv
// window2d_reframer
//
// Rebuilds a full raster frame from the interior-only result stream of a
// WIN_SIZE x WIN_SIZE window filter. Results are buffered in a small FIFO.
// BORDER_VAL is inserted at every position the window cannot cover, and the
// output is a ready/valid raster that carries start-of-frame and end-of-line
// markers.
//
// Optional feature (compile-time macro WINDOW2D_REFRAMER_CROP_EN):
//   defined   - only the interior (IMG_W-2H) x (IMG_H-2H) raster is emitted.
//               Every beat is a FIFO pop, and BORDER_VAL is never selected.
//   undefined - the full IMG_W x IMG_H raster is emitted, with border pixels.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; flushes the FIFO and the frame
//   res_valid  a filter result is present (upstream cannot be stalled)
//   res_pixel  filter result value
//   out_valid  output beat present
//   out_ready  downstream accepts the beat
//   out_pixel  output pixel
//   out_sof    beat is pixel (0,0) of the frame
//   out_eol    beat is the last pixel of its line
//   overflow   sticky: a result arrived while the FIFO was full and was lost

module window2d_reframer #(
   parameter int                DATA_W     = 8,
   parameter int                IMG_W      = 640,
   parameter int                IMG_H      = 480,
   parameter int                WIN_SIZE   = 3,
   parameter int                FIFO_DEPTH = 16,
   parameter logic [DATA_W-1:0] BORDER_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              res_valid,
   input  logic [DATA_W-1:0] res_pixel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_pixel,
   output logic              out_sof,
   output logic              out_eol,
   output logic              overflow
);

   localparam int H = (WIN_SIZE - 1) / 2;

`ifdef WINDOW2D_REFRAMER_CROP_EN
   localparam int OUT_W = IMG_W - 2 * H;
   localparam int OUT_H = IMG_H - 2 * H;
`else
   localparam int OUT_W = IMG_W;
   localparam int OUT_H = IMG_H;
`endif

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifndef WINDOW2D_REFRAMER_CROP_EN
   localparam logic [COL_W-1:0] COL_LO = COL_W'(H);
   localparam logic [COL_W-1:0] COL_HI = COL_W'(IMG_W - 1 - H);
   localparam logic [ROW_W-1:0] ROW_LO = ROW_W'(H);
   localparam logic [ROW_W-1:0] ROW_HI = ROW_W'(IMG_H - 1 - H);
`endif

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t state, state_next;

   // row/col is the position of the beat currently presented (or awaited).
   logic [ROW_W-1:0]  row, row_next;
   logic [COL_W-1:0]  col, col_next;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_inc;
   logic [CNT_W-1:0]  count, count_next;
   logic [DATA_W-1:0] head_next;

   logic accept, pop, push, at_last;
   logic cur_border, next_border;

   logic              out_valid_next;
   logic [DATA_W-1:0] out_pixel_next;
   logic              out_sof_next;
   logic              out_eol_next;

`ifdef WINDOW2D_REFRAMER_CROP_EN
   assign cur_border  = 1'b0;
   assign next_border = 1'b0;
`else
   function automatic logic border_at(input logic [ROW_W-1:0] r,
                                      input logic [COL_W-1:0] c);
      return (r < ROW_LO) || (r > ROW_HI) || (c < COL_LO) || (c > COL_HI);
   endfunction

   assign cur_border  = border_at(row, col);
   assign next_border = border_at(row_next, col_next);
`endif

   // Raster position advance on every accepted beat.
   always_comb begin
      accept   = out_valid && out_ready;
      at_last  = (row == ROW_LAST) && (col == COL_LAST);
      row_next = row;
      col_next = col;
      if (accept) begin
         if (col == COL_LAST) begin
            col_next = '0;
            row_next = (row == ROW_LAST) ? '0 : row + 1'b1;
         end else begin
            col_next = col + 1'b1;
         end
      end
   end

   // FIFO control. A push is allowed while the FIFO is full if a pop frees a
   // slot in the same cycle. head_next is the FIFO head as it will be after
   // this edge. It is used to preload the output register, so that interior
   // pixels stream at full rate. When the FIFO drains, the value arriving this
   // cycle becomes the head.
   always_comb begin
      pop        = accept && !cur_border;
      push       = res_valid && ((count != CNT_FULL) || pop);
      rd_ptr_inc = rd_ptr + 1'b1;
      count_next = count;
      if (push && !pop) begin
         count_next = count + 1'b1;
      end else if (pop && !push) begin
         count_next = count - 1'b1;
      end
      head_next = res_pixel;
      if (pop) begin
         if (count > CNT_ONE) begin
            head_next = mem[rd_ptr_inc];
         end
      end else if (count != '0) begin
         head_next = mem[rd_ptr];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         row   <= '0;
         col   <= '0;
      end else begin
         state <= state_next;
         row   <= row_next;
         col   <= col_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (count != '0) state_next = STREAM;
         STREAM:  if (accept && at_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The output register reloads whenever it is not holding an unaccepted
   // beat. While a beat is pending, every field stays frozen. An interior
   // position with an empty FIFO reloads each cycle until data shows up.
   always_comb begin
      out_valid_next = out_valid;
      out_pixel_next = out_pixel;
      out_sof_next   = out_sof;
      out_eol_next   = out_eol;
      if (!(out_valid && !out_ready)) begin
         if (state_next == IDLE) begin
            out_valid_next = 1'b0;
            out_pixel_next = '0;
            out_sof_next   = 1'b0;
            out_eol_next   = 1'b0;
         end else begin
            out_sof_next = (row_next == '0) && (col_next == '0);
            out_eol_next = (col_next == COL_LAST);
            if (next_border) begin
               out_valid_next = 1'b1;
               out_pixel_next = BORDER_VAL;
            end else begin
               out_valid_next = (count_next != '0);
               out_pixel_next = head_next;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_pixel <= '0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
      end else begin
         out_valid <= out_valid_next;
         out_pixel <= out_pixel_next;
         out_sof   <= out_sof_next;
         out_eol   <= out_eol_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (pop)  rd_ptr <= rd_ptr_inc;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         count <= count_next;
         if (res_valid && !push) overflow <= 1'b1;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= res_pixel;
   end

endmodule

// File: tb/tb_window2d_reframer.sv
// tb_window2d_reframer
//
// Self-checking bench for window2d_reframer on a 6x5 frame with a 3x3 window.
// The behavioural model builds the expected beat list by walking the raster.
// It takes a result at each interior position and inserts the border value
// everywhere else. A second instance with a 4-entry FIFO covers overflow.
// Build with +define+WINDOW2D_REFRAMER_CROP_EN to test the cropped geometry.

module tb_window2d_reframer;

   localparam int IMG_W = 6;
   localparam int IMG_H = 5;
   localparam int WIN   = 3;
   localparam int HB    = (WIN - 1) / 2;
   localparam int N_INT = (IMG_W - 2 * HB) * (IMG_H - 2 * HB);
   localparam logic [7:0] BORDER = 8'h00;

`ifdef WINDOW2D_REFRAMER_CROP_EN
   localparam bit CROP   = 1'b1;
   localparam int OW     = IMG_W - 2 * HB;
   localparam int OH     = IMG_H - 2 * HB;
   localparam int N_GOLD = 5;
`else
   localparam bit CROP   = 1'b0;
   localparam int OW     = IMG_W;
   localparam int OH     = IMG_H;
   localparam int N_GOLD = 10;
`endif

   typedef struct {
      logic [7:0] pixel;
      logic       sof;
      logic       eol;
   } beat_t;

   typedef struct {
      int         idx;
      logic [7:0] pixel;
      logic       sof;
      logic       eol;
   } golden_t;

   typedef struct {
      int period;
      int ready_mode;
   } scen_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       res_valid, out_ready, out_valid, out_sof, out_eol, overflow;
   logic [7:0] res_pixel, out_pixel;
   logic       s_res_valid, s_out_ready, s_out_valid, s_out_sof, s_out_eol, s_overflow;
   logic [7:0] s_res_pixel, s_out_pixel;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;
   bit sel_small = 1'b0;

   beat_t      got_q[$];
   int         got_cyc[$];
   beat_t      exp_q[$];
   logic [7:0] mdl_res[$];
   logic [7:0] stim_vals[$];
   int         start_cyc;

   golden_t gold[N_GOLD];
   scen_t   scen[3];

   window2d_reframer #(
      .DATA_W(8), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN_SIZE(WIN),
      .FIFO_DEPTH(16), .BORDER_VAL(BORDER)
   ) dut (
      .clk(clk), .rst(rst), .res_valid(res_valid), .res_pixel(res_pixel),
      .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
      .out_sof(out_sof), .out_eol(out_eol), .overflow(overflow)
   );

   window2d_reframer #(
      .DATA_W(8), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN_SIZE(WIN),
      .FIFO_DEPTH(4), .BORDER_VAL(BORDER)
   ) dut_small (
      .clk(clk), .rst(rst), .res_valid(s_res_valid), .res_pixel(s_res_pixel),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_pixel(s_out_pixel),
      .out_sof(s_out_sof), .out_eol(s_out_eol), .overflow(s_overflow)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic beat_t mkBeat(input logic [7:0] p, input logic s, input logic e);
      beat_t b;
      b.pixel = p;
      b.sof   = s;
      b.eol   = e;
      return b;
   endfunction

   function automatic bit isBorder(input int r, input int c);
      return !CROP && (r < HB || r > IMG_H - 1 - HB || c < HB || c > IMG_W - 1 - HB);
   endfunction

   // Expected beats for one frame. The walk stops at the first interior
   // position for which no result is available: that is where the DUT stalls.
   task automatic modelFrame();
      for (int r = 0; r < OH; r++) begin
         for (int c = 0; c < OW; c++) begin
            if (isBorder(r, c)) begin
               exp_q.push_back(mkBeat(BORDER, r == 0 && c == 0, c == OW - 1));
            end else if (mdl_res.size() == 0) begin
               return;
            end else begin
               exp_q.push_back(mkBeat(mdl_res.pop_front(), r == 0 && c == 0, c == OW - 1));
            end
         end
      end
   endtask

   // Main-instance monitor. It also checks that a pending beat stays frozen.
   logic  prev_hold = 1'b0;
   beat_t prev_beat;
   always @(negedge clk) begin
      if (rst || sel_small) begin
         prev_hold <= 1'b0;
      end else begin
         if (prev_hold) begin
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_pixel", 32'(out_pixel), 32'(prev_beat.pixel));
            checkOutput("hold_sof", 32'(out_sof), 32'(prev_beat.sof));
            checkOutput("hold_eol", 32'(out_eol), 32'(prev_beat.eol));
         end
         if (out_valid && out_ready) begin
            got_q.push_back(mkBeat(out_pixel, out_sof, out_eol));
            got_cyc.push_back(cyc);
         end
         prev_hold <= out_valid && !out_ready;
         prev_beat <= mkBeat(out_pixel, out_sof, out_eol);
      end
   end

   always @(negedge clk) begin
      if (sel_small && !rst && s_out_valid && s_out_ready) begin
         got_q.push_back(mkBeat(s_out_pixel, s_out_sof, s_out_eol));
         got_cyc.push_back(cyc);
      end
   end

   // ready_mode: 0 = always ready, 1 = toggling 1,0,1,0, 2 = random.
   // period: cycles between results; 0 gives random gaps.
   // base < 0 gives random data; otherwise the values are base+1, base+2, ...
   task automatic applyStimulus(input int period, input int ready_mode, input int base, input int n_res);
      int gap;
      stim_vals.delete();
      for (int i = 0; i < n_res; i++) begin
         stim_vals.push_back((base < 0) ? 8'($urandom_range(1, 255)) : 8'(base + i + 1));
         mdl_res.push_back(stim_vals[i]);
      end
      modelFrame();
      fork
         begin
            for (int i = 0; i < n_res; i++) begin
               @(posedge clk); #1;
               if (i == 0) start_cyc = cyc;
               res_valid = 1'b1;
               res_pixel = stim_vals[i];
               gap = (period == 0) ? int'($urandom_range(0, 3)) : period - 1;
               repeat (gap) begin
                  @(posedge clk); #1;
                  res_valid = 1'b0;
               end
            end
            @(posedge clk); #1;
            res_valid = 1'b0;
         end
         begin
            for (int k = 0; k < 800 && got_q.size() < exp_q.size(); k++) begin
               case (ready_mode)
                  0:       out_ready = 1'b1;
                  1:       out_ready = (k % 2 == 0);
                  default: out_ready = ($urandom_range(0, 3) != 0);
               endcase
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
   endtask

   task automatic compareBeats(input string tag);
      repeat (8) @(posedge clk);
      #1;
      checkOutput({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checkOutput($sformatf("%s_pix%0d", tag, i), 32'(got_q[i].pixel), 32'(exp_q[i].pixel));
         checkOutput($sformatf("%s_sof%0d", tag, i), 32'(got_q[i].sof), 32'(exp_q[i].sof));
         checkOutput($sformatf("%s_eol%0d", tag, i), 32'(got_q[i].eol), 32'(exp_q[i].eol));
      end
   endtask

   task automatic checkGolden(input string tag);
      for (int g = 0; g < N_GOLD; g++) begin
         checkOutput($sformatf("%s_gold%0d_present", tag, gold[g].idx),
                     32'(got_q.size() > gold[g].idx), 32'd1);
         if (got_q.size() > gold[g].idx) begin
            checkOutput($sformatf("%s_gold%0d_pix", tag, gold[g].idx), 32'(got_q[gold[g].idx].pixel), 32'(gold[g].pixel));
            checkOutput($sformatf("%s_gold%0d_sof", tag, gold[g].idx), 32'(got_q[gold[g].idx].sof), 32'(gold[g].sof));
            checkOutput($sformatf("%s_gold%0d_eol", tag, gold[g].idx), 32'(got_q[gold[g].idx].eol), 32'(gold[g].eol));
         end
      end
   endtask

   task automatic clearQ();
      got_q.delete();
      got_cyc.delete();
      exp_q.delete();
      mdl_res.delete();
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_pixel"}, 32'(out_pixel), 32'd0);
      checkOutput({tag, "_sof"}, 32'(out_sof), 32'd0);
      checkOutput({tag, "_eol"}, 32'(out_eol), 32'd0);
      checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
      checkOutput({tag, "_s_valid"}, 32'(s_out_valid), 32'd0);
      checkOutput({tag, "_s_overflow"}, 32'(s_overflow), 32'd0);
   endtask

   initial begin
`ifdef WINDOW2D_REFRAMER_CROP_EN
      gold = '{'{0, 8'd1, 1'b1, 1'b0}, '{3, 8'd4, 1'b0, 1'b1}, '{4, 8'd5, 1'b0, 1'b0},
               '{7, 8'd8, 1'b0, 1'b1}, '{11, 8'd12, 1'b0, 1'b1}};
`else
      gold = '{'{0, 8'd0, 1'b1, 1'b0}, '{5, 8'd0, 1'b0, 1'b1}, '{6, 8'd0, 1'b0, 1'b0},
               '{7, 8'd1, 1'b0, 1'b0}, '{10, 8'd4, 1'b0, 1'b0}, '{11, 8'd0, 1'b0, 1'b1},
               '{13, 8'd5, 1'b0, 1'b0}, '{22, 8'd12, 1'b0, 1'b0}, '{24, 8'd0, 1'b0, 1'b0},
               '{29, 8'd0, 1'b0, 1'b1}};
`endif
      scen = '{'{1, 0}, '{1, 1}, '{4, 0}};

      rst = 1'b1;
      res_valid = 1'b0;   res_pixel = 8'h00;   out_ready = 1'b1;
      s_res_valid = 1'b0; s_res_pixel = 8'h00; s_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkResetState("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      for (int s = 0; s < 3; s++) begin
         applyStimulus(scen[s].period, scen[s].ready_mode, 0, N_INT);
         compareBeats($sformatf("scen%0d", s));
         checkGolden($sformatf("scen%0d", s));
         if (scen[s].ready_mode == 0 && got_cyc.size() > 0) begin
            checkOutput($sformatf("scen%0d_latency", s), 32'(got_cyc[0] - start_cyc), 32'd2);
         end
         if (scen[s].ready_mode == 0 && scen[s].period == 1 && got_cyc.size() == OW * OH) begin
            checkOutput($sformatf("scen%0d_frame_cycles", s),
                        32'(got_cyc[OW * OH - 1] - got_cyc[0]), 32'(OW * OH - 1));
         end
         if (!CROP && scen[s].period == 4 && got_cyc.size() >= OW) begin
            checkOutput($sformatf("scen%0d_row0_span", s), 32'(got_cyc[OW - 1] - got_cyc[0]), 32'(OW - 1));
         end
         clearQ();
         repeat (4) @(posedge clk);
         #1;
      end

      for (int f = 0; f < 3; f++) begin
         applyStimulus(0, 2, -1, N_INT);
         compareBeats($sformatf("rand%0d", f));
         clearQ();
      end
      checkOutput("no_overflow", 32'(overflow), 32'd0);

      // Six results stall the frame partway through the interior. A reset
      // there must discard it, and the next frame must start clean.
      applyStimulus(1, 0, 50, 6);
      repeat (10) @(posedge clk);
      #1;
      compareBeats("partial");
      clearQ();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkResetState("midrst");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(1, 0, 100, N_INT);
      compareBeats("after_rst");
      clearQ();

      // Overflow on the 4-entry instance, with downstream stalled.
      sel_small = 1'b1;
      s_out_ready = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         s_res_valid = 1'b1;
         s_res_pixel = 8'(i);
         @(negedge clk);
         checkOutput($sformatf("ovf_cycle%0d", i), 32'(s_overflow), 32'(i > 5));
      end
      @(posedge clk); #1;
      s_res_valid = 1'b0;
      for (int i = 1; i <= 4; i++) mdl_res.push_back(8'(i));
      modelFrame();
      s_out_ready = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      compareBeats("ovf_drain");
      checkOutput("ovf_sticky", 32'(s_overflow), 32'd1);
      clearQ();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("ovf_cleared", 32'(s_overflow), 32'd0);
      rst = 1'b0;
      sel_small = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
